ps2_direction_rx: RTL

//  PS/2 keyboard receiver, upstream of the snake game core. Deserialises device-to-host frames from the SCL/SDA pins
//  and decodes arrow-key make codes (scan set 2) into the 3-bit direction bus the game core consumes.

---
 rtl/ps2_direction_rx_pkg.sv | 32 +++
 rtl/ps2_direction_rx_if.sv | 14 +
 rtl/ps2_frame_rx.sv | 116 +++++++++++
 rtl/ps2_direction_rx.sv | 98 +++++++++
 4 files changed

// File: rtl/ps2_direction_rx_pkg.sv
// Shared encodings for the PS/2 direction receiver and the snake game core:
// direction bus values, scan set 2 codes of interest, frame FSM states.
package ps2_direction_rx_pkg;

    localparam logic [2:0] DIR_RIGHT = 3'b000;
    localparam logic [2:0] DIR_DOWN  = 3'b001;
    localparam logic [2:0] DIR_LEFT  = 3'b010;
    localparam logic [2:0] DIR_UP    = 3'b011;
    localparam logic [2:0] DIR_STOP  = 3'b100;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_DATA,
        FR_PARITY,
        FR_STOP
    } frame_state_t;

    // Two moving directions are opposite when they differ only in bit 1
    // (right/left, down/up); STOP is never opposite to anything.
    function automatic logic is_opposite(input logic [2:0] cur, input logic [2:0] req);
        return !cur[2] && !req[2] && ((cur[1:0] ^ req[1:0]) == 2'b10);
    endfunction

endpackage

// File: rtl/ps2_direction_rx_if.sv
// Pin-side and game-side signals of the PS/2 direction receiver.
// master: keyboard/test side; slave: the receiver itself.
interface ps2_direction_rx_if;
    logic       SCL;
    logic       SDA;
    logic [2:0] direction;
    logic       key_valid;
    logic       frame_err;

    modport master (output SCL, output SDA,
                    input direction, input key_valid, input frame_err);
    modport slave  (input SCL, input SDA,
                    output direction, output key_valid, output frame_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, SCL falling-edge
// detect, start/data/parity/stop FSM and an inter-edge watchdog.
module ps2_frame_rx
    import ps2_direction_rx_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TIMEOUT_US  = 2000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int LIMIT = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int WD_W  = $clog2(LIMIT + 1);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   scl_s;
    logic                   sda_s;
    logic                   fall;

    frame_state_t           state;
    logic [2:0]             bit_cnt;
    logic                   par_ok;
    logic [WD_W-1:0]        wd_cnt;
    logic [7:0]             shreg;

    assign scl_s   = scl_sync[SYNC_STAGES-1];
    assign sda_s   = sda_sync[SYNC_STAGES-1];
    assign fall    = scl_prev && !scl_s;
    assign rx_byte = shreg;

    // Synchronise both pins; reset to the idle-high bus level so release
    // of reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_prev <= scl_s;
        end
    end

    // Data shifter, LSB first; holds the completed byte while byte_valid pulses.
    always_ff @(posedge clk) begin
        if (fall && state == FR_DATA) begin
            shreg <= {sda_s, shreg[7:1]};
        end
    end

    // Frame FSM with watchdog; a timeout wins only when no edge arrives that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FR_IDLE;
            bit_cnt    <= 3'd0;
            par_ok     <= 1'b0;
            wd_cnt     <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state != FR_IDLE && !fall && wd_cnt == WD_W'(LIMIT - 1)) begin
                state     <= FR_IDLE;
                wd_cnt    <= '0;
                frame_err <= 1'b1;
            end else begin
                if (state == FR_IDLE || fall) begin
                    wd_cnt <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
                if (fall) begin
                    case (state)
                        FR_IDLE: begin
                            if (!sda_s) begin
                                state   <= FR_DATA;
                                bit_cnt <= 3'd0;
                            end
                        end
                        FR_DATA: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= FR_PARITY;
                            end
                        end
                        FR_PARITY: begin
                            par_ok <= ^{shreg, sda_s};
                            state  <= FR_STOP;
                        end
                        FR_STOP: begin
                            if (sda_s && par_ok) begin
                                byte_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= FR_IDLE;
                        end
                        default: state <= FR_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/ps2_direction_rx.sv
// PS/2 arrow-key decoder for the snake game: receives frames, tracks the
// E0/F0 prefixes and drives the 3-bit direction bus with a key_valid strobe.
// Optional build macro PS2_REVERSE_BLOCK_EN: ignore makes that request the
// direct opposite of the current direction.
module ps2_direction_rx
    import ps2_direction_rx_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TIMEOUT_US  = 2000,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_game,
    ps2_direction_rx_if.slave bus
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;
    logic       ext;
    logic       brk;
    logic [2:0] dir_q;
    logic       kv_q;
    logic [2:0] req;
    logic       hit;
    logic       accept;

    ps2_frame_rx #(
        .CLK_HZ      (CLK_HZ),
        .TIMEOUT_US  (TIMEOUT_US),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_frame (
        .clk        (clk),
        .rst_n      (rst_game),
        .scl        (bus.SCL),
        .sda        (bus.SDA),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign bus.direction = dir_q;
    assign bus.key_valid = kv_q;
    assign bus.frame_err = frame_err;

    // Map the current byte to a requested direction when it is a usable make.
    always_comb begin
        req = DIR_STOP;
        hit = 1'b0;
        if (!brk) begin
            if (ext) begin
                case (rx_byte)
                    SC_RIGHT: begin req = DIR_RIGHT; hit = 1'b1; end
                    SC_DOWN:  begin req = DIR_DOWN;  hit = 1'b1; end
                    SC_LEFT:  begin req = DIR_LEFT;  hit = 1'b1; end
                    SC_UP:    begin req = DIR_UP;    hit = 1'b1; end
                    default:  ;
                endcase
            end else if (rx_byte == SC_SPACE) begin
                req = DIR_STOP;
                hit = 1'b1;
            end
        end
    end

`ifdef PS2_REVERSE_BLOCK_EN
    assign accept = hit && !is_opposite(dir_q, req);
`else
    assign accept = hit;
`endif

    // Prefix tracking and direction register; prefixes clear on any other byte.
    always_ff @(posedge clk or negedge rst_game) begin
        if (!rst_game) begin
            dir_q <= DIR_STOP;
            kv_q  <= 1'b0;
            ext   <= 1'b0;
            brk   <= 1'b0;
        end else begin
            kv_q <= 1'b0;
            if (byte_valid) begin
                if (rx_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (accept) begin
                        dir_q <= req;
                        kv_q  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
